// File: rtl/debug_dump_unit.sv
// Debug snapshot streamer: freezes N channels, sweeps data memory, emits bytes on a valid/ready link.
// Optional trailing XOR checksum byte when DEBUG_DUMP_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module debug_dump_unit #(
  parameter int NUM_CH          = 4,
  parameter int CH_BITS         = 64,
  parameter int PROC_BITS       = 32,
  parameter int DATA_ADDRS_BITS = 5,
  parameter int MEM_WORDS       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [NUM_CH*CH_BITS-1:0]   i_snapshot,
  input  logic [PROC_BITS-1:0]        i_mem_data,
  output logic                        o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address,
  output logic                        o_dp_enable,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int SNAP_BITS  = NUM_CH * CH_BITS;
  localparam int SNAP_BYTES = SNAP_BITS / 8;
  localparam int WORD_BYTES = PROC_BITS / 8;
  localparam int MAX_BYTES  = (SNAP_BYTES > WORD_BYTES) ? SNAP_BYTES : WORD_BYTES;
  localparam int IDX_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  localparam logic [IDX_W-1:0]           SNAP_LAST = IDX_W'(SNAP_BYTES - 1);
  localparam logic [IDX_W-1:0]           WORD_LAST = IDX_W'(WORD_BYTES - 1);
  localparam logic [DATA_ADDRS_BITS-1:0] LAST_ADDR = DATA_ADDRS_BITS'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_MEM_REQ,
    S_MEM_CAPT,
    S_MEM_SEND,
`ifdef DEBUG_DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [SNAP_BITS-1:0]        shadow_q, shadow_d;
  logic [PROC_BITS-1:0]        word_q, word_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DATA_ADDRS_BITS-1:0]  addr_q, addr_d;
  logic [7:0]                  tx_data_q, tx_data_d;
  logic                        tx_valid_q, tx_valid_d;
  logic                        rd_q, rd_d;
  logic                        dp_en_q, dp_en_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0]                  csum_q, csum_d;
`endif
  logic                        xfer;

  assign xfer = tx_valid_q && i_tx_ready;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    word_d     = word_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rd_d       = rd_q;
    dp_en_d    = dp_en_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    csum_d     = csum_q;
    if (xfer) csum_d = csum_q ^ tx_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_SNAP;
          shadow_d   = i_snapshot;
          idx_d      = '0;
          tx_data_d  = i_snapshot[7:0];
          tx_valid_d = 1'b1;
          dp_en_d    = 1'b0;
          busy_d     = 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      S_SNAP: begin
        if (xfer) begin
          if (idx_q == SNAP_LAST) begin
            state_d    = S_MEM_REQ;
            tx_valid_d = 1'b0;
            addr_d     = '0;
            rd_d       = 1'b1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = shadow_q[8*(int'(idx_q) + 1) +: 8];
          end
        end
      end

      S_MEM_REQ: state_d = S_MEM_CAPT;

      // Read data is valid during MEM_CAPT; the first byte is presented straight from the bus.
      S_MEM_CAPT: begin
        state_d    = S_MEM_SEND;
        rd_d       = 1'b0;
        word_d     = i_mem_data;
        idx_d      = '0;
        tx_data_d  = i_mem_data[7:0];
        tx_valid_d = 1'b1;
      end

      S_MEM_SEND: begin
        if (xfer) begin
          if (idx_q == WORD_LAST) begin
            if (addr_q == LAST_ADDR) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
              state_d    = S_CSUM;
              tx_data_d  = csum_q ^ tx_data_q;
`else
              state_d    = S_DONE;
              tx_valid_d = 1'b0;
              done_d     = 1'b1;
`endif
            end else begin
              state_d    = S_MEM_REQ;
              tx_valid_d = 1'b0;
              addr_d     = addr_q + DATA_ADDRS_BITS'(1);
              rd_d       = 1'b1;
            end
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = word_q[8*(int'(idx_q) + 1) +: 8];
          end
        end
      end

`ifdef DEBUG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d    = S_DONE;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        dp_en_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_q       <= 1'b0;
      dp_en_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rd_q       <= rd_d;
      dp_en_q    <= dp_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign o_debug_read_data    = rd_q;
  assign o_debug_read_address = addr_q;
  assign o_dp_enable          = dp_en_q;
  assign o_tx_data            = tx_data_q;
  assign o_tx_valid           = tx_valid_q;
  assign o_busy               = busy_q;
  assign o_done               = done_q;

endmodule

// File: tb/tb_debug_dump_unit.sv
// Bench for debug_dump_unit: a short-sweep instance for handshake/reset cases and a full 32-word sweep.
`timescale 1ns/1ps
module tb_debug_dump_unit;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, ready_a, rd_a, dpen_a, txv_a, busy_a, done_a;
  logic [31:0] snap_a, mdata_a;
  logic [4:0]  addr_a;
  logic [7:0]  txd_a;

  logic        start_b, ready_b, rd_b, dpen_b, txv_b, busy_b, done_b;
  logic [31:0] snap_b, mdata_b;
  logic [4:0]  addr_b;
  logic [7:0]  txd_b;

  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];

  int checks = 0;
  int errors = 0;

  debug_dump_unit #(.NUM_CH(2), .CH_BITS(16), .PROC_BITS(32), .DATA_ADDRS_BITS(5), .MEM_WORDS(2)) u_dut (
    .clk(clk), .rst(rst), .i_start(start_a), .i_snapshot(snap_a), .i_mem_data(mdata_a),
    .o_debug_read_data(rd_a), .o_debug_read_address(addr_a), .o_dp_enable(dpen_a),
    .o_tx_data(txd_a), .o_tx_valid(txv_a), .i_tx_ready(ready_a), .o_busy(busy_a), .o_done(done_a));

  debug_dump_unit #(.NUM_CH(2), .CH_BITS(16), .PROC_BITS(32), .DATA_ADDRS_BITS(5), .MEM_WORDS(32)) u_full (
    .clk(clk), .rst(rst), .i_start(start_b), .i_snapshot(snap_b), .i_mem_data(mdata_b),
    .o_debug_read_data(rd_b), .o_debug_read_address(addr_b), .o_dp_enable(dpen_b),
    .o_tx_data(txd_b), .o_tx_valid(txv_b), .i_tx_ready(ready_b), .o_busy(busy_b), .o_done(done_b));

  // Memories with one-cycle read latency; junk on the bus when not strobed.
  logic       ra_s, rb_s;
  logic [4:0] aa_s, ab_s;
  always @(posedge clk) begin
    ra_s = rd_a; aa_s = addr_a;
    rb_s = rd_b; ab_s = addr_b;
    #1;
    mdata_a = ra_s ? mem_a[aa_s] : $urandom();
    mdata_b = rb_s ? mem_b[ab_s] : $urandom();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_stream(input logic [31:0] snap, input int words, input bit from_b,
                                       output logic [7:0] q [$]);
    logic [7:0] x;
    logic [31:0] w;
    q = {};
    for (int b = 0; b < 4; b++) q.push_back(snap[8*b +: 8]);
    for (int i = 0; i < words; i++) begin
      w = from_b ? mem_b[i] : mem_a[i];
      for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
    end
    if (CSUM_EN) begin
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      q.push_back(x);
    end
  endfunction

  logic [7:0] got_q [$];

  // mode: 0 ready always, 1 random ready, 2 stall 5 cycles on byte 2, 3 start while busy, 4 reset after 3rd byte
  task automatic run_dump(input string tag, input int mode);
    logic [7:0] exp_q [$];
    int         ndone, stall, s;
    bit         done_seen, prev_hold, restarted, finished;
    logic [7:0] prev_data;
    build_stream(snap_a, 2, 1'b0, exp_q);
    got_q = {};
    ndone = 0; stall = 5; done_seen = 0; prev_hold = 0; restarted = 0; finished = 0;
    prev_data = 8'h00;
    @(negedge clk);
    start_a = 1'b1;
    ready_a = 1'b1;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (cyc == 1) snap_a = $urandom();
      s = got_q.size();
      if (mode == 4 && s == 3) begin
        rst = 1'b1;
        #1;
        chk({tag, ":rst_valid"}, 32'(txv_a), 32'd0);
        chk({tag, ":rst_busy"}, 32'(busy_a), 32'd0);
        chk({tag, ":rst_dpen"}, 32'(dpen_a), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        finished = 1;
      end else if (done_seen) begin
        chk({tag, ":post_busy"}, 32'(busy_a), 32'd0);
        chk({tag, ":post_dpen"}, 32'(dpen_a), 32'd1);
        chk({tag, ":post_done"}, 32'(done_a), 32'd0);
        finished = 1;
      end else begin
        chk({tag, ":busy"}, 32'(busy_a), 32'd1);
        chk({tag, ":dpen"}, 32'(dpen_a), 32'd0);
        if (prev_hold) begin
          chk({tag, ":hold_valid"}, 32'(txv_a), 32'd1);
          chk({tag, ":hold_data"}, 32'(txd_a), 32'(prev_data));
        end
        if (s < 4 || (s < 12 && ((s - 4) % 4) != 0))
          chk({tag, ":no_gap"}, 32'(txv_a), 32'd1);
        case (mode)
          1: ready_a = ($urandom_range(0, 3) != 0);
          2: if (txv_a && s == 2 && stall > 0) begin
               ready_a = 1'b0;
               stall--;
               chk({tag, ":stall_byte"}, 32'(txd_a), 32'(exp_q[2]));
             end else ready_a = 1'b1;
          default: ready_a = 1'b1;
        endcase
        if (mode == 3 && !restarted && s == 5 && txv_a) begin
          start_a = 1'b1;
          restarted = 1;
        end
        if (txv_a && ready_a) got_q.push_back(txd_a);
        prev_hold = txv_a && !ready_a;
        prev_data = txd_a;
        if (done_a) begin
          ndone++;
          done_seen = 1;
        end
      end
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    chk({tag, ":terminated"}, 32'(finished), 32'd1);
    if (mode == 4) begin
      chk({tag, ":done_count"}, 32'(ndone), 32'd0);
      chk({tag, ":len"}, 32'(got_q.size()), 32'd3);
    end else begin
      chk({tag, ":done_count"}, 32'(ndone), 32'd1);
      chk({tag, ":len"}, 32'(got_q.size()), 32'(exp_q.size()));
    end
    foreach (got_q[i])
      if (i < exp_q.size()) chk($sformatf("%s:byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  logic [7:0] t1 [0:11];
  logic [7:0] tail [0:3];

  task automatic set_directed();
    snap_a   = 32'hDDCCBBAA;
    mem_a[0] = 32'h11223344;
    mem_a[1] = 32'h55667788;
  endtask

  initial begin
    logic [7:0]  exp_b [$];
    logic [31:0] snap_saved;
    int          cnt [0:31];
    int          addr_seq [$];
    int          ndone_b;
    bit          prev_rd, fin;

    t1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    tail = '{8'h1F, 8'h00, 8'h00, 8'h00};
    rst = 1'b1;
    start_a = 0; ready_a = 1; snap_a = 0;
    start_b = 0; ready_b = 1; snap_b = 0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = $urandom();
      mem_b[i] = 32'(i);
    end
    repeat (3) @(negedge clk);
    chk("reset:valid", 32'(txv_a), 32'd0);
    chk("reset:busy", 32'(busy_a), 32'd0);
    chk("reset:dpen", 32'(dpen_a), 32'd1);
    chk("reset:done", 32'(done_a), 32'd0);
    chk("reset:rd", 32'(rd_a), 32'd0);
    chk("reset:addr", 32'(addr_a), 32'd0);
    chk("reset:data", 32'(txd_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    set_directed();
    run_dump("basic", 0);
    for (int i = 0; i < 12; i++)
      if (i < got_q.size()) chk($sformatf("basic:lit%0d", i), 32'(got_q[i]), 32'(t1[i]));

    set_directed();
    run_dump("stall", 2);
    for (int i = 0; i < 12; i++)
      if (i < got_q.size()) chk($sformatf("stall:lit%0d", i), 32'(got_q[i]), 32'(t1[i]));

    snap_a = $urandom(); mem_a[0] = $urandom(); mem_a[1] = $urandom();
    run_dump("start_busy", 3);

    set_directed();
    run_dump("reset_mid", 4);
    set_directed();
    run_dump("after_reset", 0);
    if (got_q.size() > 0) chk("after_reset:first", 32'(got_q[0]), 32'hAA);

    for (int r = 0; r < 5; r++) begin
      snap_a = $urandom(); mem_a[0] = $urandom(); mem_a[1] = $urandom();
      run_dump($sformatf("rand%0d", r), 1);
    end

    // Full 32-word sweep on the second instance.
    snap_b = $urandom();
    snap_saved = snap_b;
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    got_q = {};
    ndone_b = 0; prev_rd = 0; fin = 0;
    @(negedge clk);
    start_b = 1'b1;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      snap_b = $urandom();
      if (ndone_b > 0) begin
        chk("full:post_busy", 32'(busy_b), 32'd0);
        chk("full:post_rd", 32'(rd_b), 32'd0);
        fin = 1;
      end else begin
        if (rd_b) begin
          cnt[addr_b]++;
          if (!prev_rd) addr_seq.push_back(int'(addr_b));
        end
        prev_rd = rd_b;
        if (txv_b && ready_b) got_q.push_back(txd_b);
        if (done_b) ndone_b++;
      end
    end
    chk("full:terminated", 32'(fin), 32'd1);
    build_stream(snap_saved, 32, 1'b1, exp_b);
    chk("full:len", 32'(got_q.size()), 32'(exp_b.size()));
    chk("full:nreads", 32'(addr_seq.size()), 32'd32);
    foreach (addr_seq[i]) chk($sformatf("full:addr%0d", i), 32'(addr_seq[i]), 32'(i));
    for (int i = 0; i < 32; i++) chk($sformatf("full:strobe%0d", i), 32'(cnt[i]), 32'd2);
    foreach (got_q[i])
      if (i < exp_b.size()) chk($sformatf("full:byte%0d", i), 32'(got_q[i]), 32'(exp_b[i]));
    if (got_q.size() >= 132)
      for (int i = 0; i < 4; i++) chk($sformatf("full:tail%0d", i), 32'(got_q[128 + i]), 32'(tail[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
